// File: rtl/ln_row_collector.sv
// ---------------------------------------------------------------------------
// ln_row_collector
//
// Gathers BEATS consecutive beats from the layernorm output stream into one
// full row. The assembled row is presented downstream with a valid/ready
// handshake. A running count of rows handed off is kept.
//
// The datapath is a row buffer of BEATS slots. Each accepted beat is written
// into the slot selected by beat_cnt. A two-state FSM alternates between
// COLLECT, which fills the buffer, and HOLD, which presents the row. Input
// and output are never accepted in the same cycle, so there is no bypass
// path. A row therefore costs at least BEATS+1 cycles.
//
// Optional feature (macro LN_COLLECT_SAT_EN):
//   When defined, each int8 lane of an accepted beat is clamped to
//   [-127,127] before it is stored. Only 0x80 changes; it becomes 0x81.
//   When the macro is undefined, lanes are stored bit-exact.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   beat valid (layernorm data_out_valid)
//   in_ready   out  beat ready (layernorm data_out_ready)
//   in_data    in   one beat, signed int8 lane i at [8i+7:8i]
//   clear      in   synchronous abort; discards any partial or held row
//   row_valid  out  assembled row available
//   row_ready  in   downstream accepts row
//   row_data   out  assembled row, beat k at [k*DATA_W +: DATA_W]
//   row_cnt    out  rows handed off since reset (wraps)
//   busy       out  partial row in flight, or row held
// ---------------------------------------------------------------------------

// Per-lane store conditioning. This is pure combinational logic, one
// instance per int8 lane.
module ln_lane_sat (
  input  logic [7:0] lane_i,
  output logic [7:0] lane_o
);
`ifdef LN_COLLECT_SAT_EN
  // -128 is the only int8 value outside [-127,127].
  assign lane_o = (lane_i == 8'h80) ? 8'h81 : lane_i;
`else
  assign lane_o = lane_i;
`endif
endmodule

module ln_row_collector #(
  parameter int DATA_W = 256,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    clear,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [DATA_W*BEATS-1:0] row_data,
  output logic [CNT_W-1:0]        row_cnt,
  output logic                    busy
);

  localparam int NUM_LANES = DATA_W / 8;
  // At least one bit wide, so that BEATS == 1 still gives a legal counter.
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]               row_cnt_q, row_cnt_d;
  logic [BEATS-1:0][DATA_W-1:0]   row_q;
  logic [DATA_W-1:0]              beat_st;
  logic                           beat_we;

  // Lane conditioning applied on the way into the row buffer.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ln_lane_sat u_sat (
      .lane_i (in_data[8*g +: 8]),
      .lane_o (beat_st[8*g +: 8])
    );
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    row_cnt_d  = row_cnt_q;
    beat_we    = 1'b0;
    in_ready   = 1'b0;
    row_valid  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (clear) begin
          // Abort: the partial row and this cycle's beat are both dropped.
          beat_cnt_d = '0;
        end else if (in_valid) begin
          beat_we = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        row_valid = 1'b1;
        // clear wins over the row handshake, so a dropped row is not counted.
        if (clear) begin
          state_d = COLLECT;
        end else if (row_ready) begin
          row_cnt_d = row_cnt_q + CNT_W'(1);
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // Row buffer. A slot is written only while collecting, so its contents
  // stay frozen for the whole HOLD phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else if (beat_we) begin
      row_q[beat_cnt_q] <= beat_st;
    end
  end

  assign row_data = row_q;
  assign row_cnt  = row_cnt_q;
  assign busy     = (beat_cnt_q != '0) || (state_q == HOLD);

endmodule
